hl_reset_sequencer: RTL and testbench

//  Power-up and recovery sequencer that sits directly upstream of hermes_lite_core and clkmux_sdk in the

---
 rtl/hl_reset_sequencer_if.sv | 34 +++
 rtl/hl_reset_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_hl_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hl_reset_sequencer_if.sv
// Board-wrapper side bundle for hl_reset_sequencer: asynchronous status inputs plus the
// clock-select, staged resets and debug state it drives.
interface hl_reset_sequencer_if;
    logic       pll_locked;
    logic       exp_present;
    logic       clk_sel;
    logic       phy_rst_n;
    logic       ad9866_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic [2:0] state;

    modport master (
        input  pll_locked,
        input  exp_present,
        output clk_sel,
        output phy_rst_n,
        output ad9866_rst_n,
        output core_rst_n,
        output ready,
        output state
    );

    modport slave (
        output pll_locked,
        output exp_present,
        input  clk_sel,
        input  phy_rst_n,
        input  ad9866_rst_n,
        input  core_rst_n,
        input  ready,
        input  state
    );
endinterface

// File: rtl/hl_reset_sequencer.sv
// Power-up / recovery sequencer: qualifies PLL lock and expansion-clock presence, picks the
// AD9866 clock mux input, then releases PHY, AD9866 and core resets in stages.
module hl_reset_sequencer #(
    parameter int unsigned LOCK_STABLE  = 1000,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned CLKSW_CYC    = 64,
    parameter int unsigned PHY_RST_CYC  = 500000,
    parameter int unsigned PHY_WAIT_CYC = 250000,
    parameter int unsigned AD_RST_CYC   = 1000
) (
    input  logic                  clk50mhz,
    input  logic                  rst_n,
    hl_reset_sequencer_if.master  bus
);

    localparam int unsigned MAX_A   = (LOCK_STABLE  > DEBOUNCE_CYC) ? LOCK_STABLE  : DEBOUNCE_CYC;
    localparam int unsigned MAX_B   = (CLKSW_CYC    > PHY_RST_CYC)  ? CLKSW_CYC    : PHY_RST_CYC;
    localparam int unsigned MAX_C   = (PHY_WAIT_CYC > AD_RST_CYC)   ? PHY_WAIT_CYC : AD_RST_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned TMR_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam int unsigned LOCK_W  = $clog2(LOCK_STABLE + 1);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [LOCK_W-1:0] LOCK_MAX   = LOCK_W'(LOCK_STABLE);
    localparam logic [DB_W-1:0]   DB_MAX     = DB_W'(DEBOUNCE_CYC);
    localparam logic [TMR_W-1:0]  LD_CLKSW   = TMR_W'(CLKSW_CYC - 32'd1);
    localparam logic [TMR_W-1:0]  LD_PHY_RST = TMR_W'(PHY_RST_CYC - 32'd1);
    localparam logic [TMR_W-1:0]  LD_PHY_WT  = TMR_W'(PHY_WAIT_CYC - 32'd1);
    localparam logic [TMR_W-1:0]  LD_AD_RST  = TMR_W'(AD_RST_CYC - 32'd1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SEL_CLK   = 3'd1,
        PHY_RST   = 3'd2,
        PHY_WAIT  = 3'd3,
        AD_RST    = 3'd4,
        RUN       = 3'd5
    } state_e;

    // 2-FF synchronisers
    logic lock_meta_q, lock_s_q;
    logic exp_meta_q,  exp_s_q;

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            exp_meta_q  <= 1'b0;
            exp_s_q     <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_locked;
            lock_s_q    <= lock_meta_q;
            exp_meta_q  <= bus.exp_present;
            exp_s_q     <= exp_meta_q;
        end
    end

    // exp_present debounce: exp_cand tracks the last seen value, counter measures its stability
    logic            exp_cand_q, exp_cand_d;
    logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic            exp_db_q,   exp_db_d;
    logic            settled_q,  settled_d;

    always_comb begin
        exp_cand_d = exp_cand_q;
        db_cnt_d   = db_cnt_q;
        exp_db_d   = exp_db_q;
        settled_d  = settled_q;
        if (exp_s_q != exp_cand_q) begin
            exp_cand_d = exp_s_q;
            db_cnt_d   = '0;
            settled_d  = 1'b0;
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
            if (db_cnt_d == DB_MAX) begin
                exp_db_d  = exp_cand_q;
                settled_d = 1'b1;
            end else begin
                settled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            exp_cand_q <= 1'b0;
            db_cnt_q   <= '0;
            exp_db_q   <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            exp_cand_q <= exp_cand_d;
            db_cnt_q   <= db_cnt_d;
            exp_db_q   <= exp_db_d;
            settled_q  <= settled_d;
        end
    end

    // Lock qualifier: consecutive locked cycles, saturating
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              lock_ok_c;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lock_s_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
    end

    assign lock_ok_c = (lock_cnt_q == LOCK_MAX);

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Sequencer FSM with one shared down-counter for the timed states
    state_e             state_q,        state_d;
    logic [TMR_W-1:0]   tmr_q,          tmr_d;
    logic               clk_sel_q,      clk_sel_d;
    logic               phy_rst_n_q,    phy_rst_n_d;
    logic               ad9866_rst_n_q, ad9866_rst_n_d;
    logic               core_rst_n_q,   core_rst_n_d;
    logic               ready_q,        ready_d;
    logic               abort_c;
    logic               tmr_zero_c;

    // Abort when lock drops or the debounced clock presence disagrees with the selected mux input
    assign abort_c    = (state_q != WAIT_LOCK) &&
                        (!lock_s_q || (settled_q && (exp_db_q == clk_sel_q)));
    assign tmr_zero_c = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        clk_sel_d = clk_sel_q;

        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_ok_c && settled_q) begin
                    state_d   = SEL_CLK;
                    tmr_d     = LD_CLKSW;
                    clk_sel_d = ~exp_db_q;
                end
            end
            SEL_CLK: begin
                if (tmr_zero_c) begin
                    state_d = PHY_RST;
                    tmr_d   = LD_PHY_RST;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            PHY_RST: begin
                if (tmr_zero_c) begin
                    state_d = PHY_WAIT;
                    tmr_d   = LD_PHY_WT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            PHY_WAIT: begin
                if (tmr_zero_c) begin
                    state_d = AD_RST;
                    tmr_d   = LD_AD_RST;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            AD_RST: begin
                if (tmr_zero_c) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = WAIT_LOCK;
                tmr_d   = '0;
            end
        endcase

        if (abort_c) begin
            state_d = WAIT_LOCK;
            tmr_d   = '0;
        end

        // Outputs decoded from the next state so they register in step with state_q
        phy_rst_n_d    = (state_d == PHY_WAIT) || (state_d == AD_RST) || (state_d == RUN);
        ad9866_rst_n_d = (state_d == RUN);
        core_rst_n_d   = (state_d == RUN);
        ready_d        = (state_d == RUN);
    end

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_LOCK;
            tmr_q          <= '0;
            clk_sel_q      <= 1'b1;
            phy_rst_n_q    <= 1'b0;
            ad9866_rst_n_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            clk_sel_q      <= clk_sel_d;
            phy_rst_n_q    <= phy_rst_n_d;
            ad9866_rst_n_q <= ad9866_rst_n_d;
            core_rst_n_q   <= core_rst_n_d;
            ready_q        <= ready_d;
        end
    end

    assign bus.clk_sel      = clk_sel_q;
    assign bus.phy_rst_n    = phy_rst_n_q;
    assign bus.ad9866_rst_n = ad9866_rst_n_q;
    assign bus.core_rst_n   = core_rst_n_q;
    assign bus.ready        = ready_q;
    assign bus.state        = 3'(state_q);

endmodule

// File: tb/tb_hl_reset_sequencer.sv
// Scoreboard bench for hl_reset_sequencer: expected sequence events are queued with the stimulus
// and matched against events a negedge monitor extracts from the DUT outputs.
module tb_hl_reset_sequencer;

    localparam int unsigned LOCK_STABLE  = 8;
    localparam int unsigned DEBOUNCE_CYC = 16;
    localparam int unsigned CLKSW_CYC    = 4;
    localparam int unsigned PHY_RST_CYC  = 10;
    localparam int unsigned PHY_WAIT_CYC = 6;
    localparam int unsigned AD_RST_CYC   = 5;

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_PHY_RST   = 3'd2;
    localparam logic [2:0] S_PHY_WAIT  = 3'd3;
    localparam logic [2:0] S_AD_RST    = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;

    logic clk = 1'b0;
    logic rst_n;

    hl_reset_sequencer_if sq ();

    hl_reset_sequencer #(
        .LOCK_STABLE  (LOCK_STABLE),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CLKSW_CYC    (CLKSW_CYC),
        .PHY_RST_CYC  (PHY_RST_CYC),
        .PHY_WAIT_CYC (PHY_WAIT_CYC),
        .AD_RST_CYC   (AD_RST_CYC)
    ) dut (
        .clk50mhz (clk),
        .rst_n    (rst_n),
        .bus      (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } sb_item_t;

    sb_item_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_ev(input string tag, input int val);
        sb_item_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // One full power-up sequence: pulse widths, final mux select, all resets released
    task automatic expect_seq(input int sel);
        expect_ev("phy_w", int'(PHY_RST_CYC));
        expect_ev("ad_w", int'(AD_RST_CYC));
        expect_ev("run_sel", sel);
        expect_ev("run_rst", 7);
    endtask

    task automatic observe(input string tag, input int val);
        sb_item_t e;
        if (exp_q.size() == 0) begin
            check_eq({"extra_", tag}, val, -1);
        end else begin
            e = exp_q.pop_front();
            if (e.tag != tag) check_eq({"order_want_", e.tag, "_got_", tag}, val, e.val);
            else              check_eq(tag, val, e.val);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_state"},   int'(sq.state), 0);
        check_eq({pfx, "_clk_sel"}, int'(sq.clk_sel), 1);
        check_eq({pfx, "_phy"},     int'(sq.phy_rst_n), 0);
        check_eq({pfx, "_ad"},      int'(sq.ad9866_rst_n), 0);
        check_eq({pfx, "_core"},    int'(sq.core_rst_n), 0);
        check_eq({pfx, "_ready"},   int'(sq.ready), 0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag,
                              output int cyc);
        cyc = 0;
        while (sq.state != s && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        if (sq.state != s) check_eq({tag, "_timeout"}, int'(sq.state), int'(s));
    endtask

    task automatic lock_glitch();
        @(negedge clk);
        sq.pll_locked = 1'b0;
        @(negedge clk);
        sq.pll_locked = 1'b1;
    endtask

    // Monitor: turns output waveforms into scoreboard events
    logic [2:0] prev_state;
    int         phy_cnt;
    int         ad_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_state = S_WAIT_LOCK;
            phy_cnt    = 0;
            ad_cnt     = 0;
        end else begin
            if (sq.state == S_PHY_RST && !sq.phy_rst_n)  phy_cnt++;
            if (sq.state == S_AD_RST && !sq.ad9866_rst_n) ad_cnt++;
            if (prev_state == S_PHY_RST && sq.state != S_PHY_RST) begin
                observe("phy_w", phy_cnt);
                phy_cnt = 0;
            end
            if (prev_state == S_AD_RST && sq.state != S_AD_RST) begin
                observe("ad_w", ad_cnt);
                ad_cnt = 0;
            end
            if (prev_state != S_WAIT_LOCK && sq.state == S_WAIT_LOCK)
                observe("abort", int'({sq.ready, sq.phy_rst_n, sq.ad9866_rst_n, sq.core_rst_n}));
            if (prev_state != S_RUN && sq.state == S_RUN) begin
                observe("run_sel", int'(sq.clk_sel));
                observe("run_rst", int'({sq.phy_rst_n, sq.ad9866_rst_n, sq.core_rst_n}));
            end
            prev_state = sq.state;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n          = 1'b0;
        sq.pll_locked  = 1'b1;
        sq.exp_present = 1'b0;

        // No expansion clock: internal clock stays selected
        repeat (3) @(negedge clk);
        check_reset_vals("t2_rst");
        expect_seq(1);
        #1 rst_n = 1'b1;
        wait_state(S_RUN, 500, "t2_run", lat);

        // Expansion clock present from power-up: AD9866 clock selected, latency near 43
        @(negedge clk);
        #1 rst_n = 1'b0;
        sq.exp_present = 1'b1;
        #1 check_reset_vals("t1_rst");
        repeat (2) @(negedge clk);
        expect_seq(0);
        #1 rst_n = 1'b1;
        wait_state(S_RUN, 500, "t1_run", lat);
        check_eq("t1_ready_lat_41_45", int'(lat >= 41 && lat <= 45), 1);

        // Single-cycle lock loss in RUN
        expect_ev("abort", 0);
        expect_seq(0);
        @(negedge clk);
        sq.pll_locked = 1'b0;
        @(negedge clk);
        sq.pll_locked = 1'b1;
        lat = 1;
        while (sq.ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t3_abort_within_4", int'(lat <= 4), 1);
        check_eq("t3_state_after_abort", int'(sq.state), 0);
        wait_state(S_RUN, 500, "t3_rerun", lat);

        // Short exp_present glitch must be filtered
        @(negedge clk);
        sq.exp_present = 1'b0;
        repeat (10) @(negedge clk);
        sq.exp_present = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t4_glitch_ready", int'(sq.ready), 1);
        check_eq("t4_glitch_state", int'(sq.state), int'(S_RUN));

        // Sustained exp_present loss: abort and reselect internal clock
        expect_ev("abort", 0);
        expect_seq(1);
        sq.exp_present = 1'b0;
        wait_state(S_WAIT_LOCK, 40, "t4_abort", lat);
        wait_state(S_RUN, 500, "t4_rerun", lat);
        check_eq("t4_clk_sel", int'(sq.clk_sel), 1);

        // Lock loss during PHY_WAIT: retry repeats the full PHY pulse
        expect_ev("abort", 0);
        expect_ev("phy_w", int'(PHY_RST_CYC));
        expect_ev("abort", 0);
        expect_seq(1);
        lock_glitch();
        wait_state(S_PHY_WAIT, 500, "t5_phy_wait", lat);
        sq.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        sq.pll_locked = 1'b1;
        wait_state(S_WAIT_LOCK, 6, "t5_abort", lat);
        wait_state(S_RUN, 500, "t5_rerun", lat);

        // Back to the AD9866 clock so the async reset visibly forces clk_sel
        expect_ev("abort", 0);
        expect_seq(0);
        sq.exp_present = 1'b1;
        wait_state(S_WAIT_LOCK, 40, "t6_prep_abort", lat);
        wait_state(S_RUN, 500, "t6_prep_run", lat);
        check_eq("t6_prep_clk_sel", int'(sq.clk_sel), 0);

        // rst_n asserted mid-AD_RST: outputs return to reset values between clock edges
        expect_ev("abort", 0);
        expect_ev("phy_w", int'(PHY_RST_CYC));
        lock_glitch();
        wait_state(S_AD_RST, 500, "t6_ad_rst", lat);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6_rst");
        repeat (3) @(negedge clk);
        expect_seq(0);
        #1 rst_n = 1'b1;
        wait_state(S_RUN, 500, "t6_rerun", lat);

        repeat (5) @(negedge clk);
        check_eq("sb_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
